// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with hit counter
// Runtime-loadable pattern, valid-qualified input, overlap/non-overlap, saturating/wrapping count.
module seq_detect_param #(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1011,
  parameter int                 CNT_W    = 5,
  parameter bit                 OVERLAP  = 1'b1,
  parameter bit                 SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_value,
  input  logic               cnt_clr,
  output logic               hit,
  output logic [CNT_W-1:0]   count,
  output logic               sat
);

  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-2:0] history;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;
  logic               accept;
  logic               match;

  assign accept = din_valid & ~pat_load;
  assign window = {history, din};
  // fill guards against matching on the zeroed history before enough bits arrived
  assign match  = accept && (fill == FILL_MAX) && (window == pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= PATTERN;
      history <= '0;
      fill    <= '0;
      hit     <= 1'b0;
      count   <= '0;
      sat     <= 1'b0;
    end else if (pat_load) begin
      pattern <= pat_value;
      history <= '0;
      fill    <= '0;
      hit     <= 1'b0;
      count   <= '0;
      sat     <= 1'b0;
    end else begin
      hit <= match;
      if (accept) begin
        if (match && !OVERLAP) begin
          history <= '0;
          fill    <= '0;
        end else begin
          history <= window[PAT_LEN-2:0];
          if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
        end
      end
      // a hit coinciding with a clear is counted as the first hit after the clear
      if (cnt_clr) begin
        count <= match ? CNT_W'(1) : '0;
        sat   <= 1'b0;
      end else if (match) begin
        if (SATURATE) begin
          if (&count) sat <= 1'b1;
          else        count <= count + CNT_W'(1);
        end else begin
          count <= count + CNT_W'(1);
          if (&count) sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param
// Four parameter sets share one stimulus stream; expectations are queued at drive time.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_value = 4'b0000;
  logic       cnt_clr = 1'b0;
  logic       h0, h1, h2, h3, s0, s1, s2, s3;
  logic [4:0] c0, c1;
  logic [1:0] c2, c3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // k0 defaults, k1 non-overlap, k2 2-bit saturating, k3 2-bit wrapping
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(5), .OVERLAP(1'b1), .SATURATE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_value(pat_value), .cnt_clr(cnt_clr), .hit(h0), .count(c0), .sat(s0));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(5), .OVERLAP(1'b0), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_value(pat_value), .cnt_clr(cnt_clr), .hit(h1), .count(c1), .sat(s1));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2), .OVERLAP(1'b1), .SATURATE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_value(pat_value), .cnt_clr(cnt_clr), .hit(h2), .count(c2), .sat(s2));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2), .OVERLAP(1'b1), .SATURATE(1'b0)) dut3 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_value(pat_value), .cnt_clr(cnt_clr), .hit(h3), .count(c3), .sat(s3));

  typedef struct packed {
    logic [3:0]      h;
    logic [3:0]      s;
    logic [3:0][4:0] c;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [3:0]  mpat;
  logic [31:0] mhist [4];
  int          mn    [4];
  int          mc    [4];
  bit          ms    [4];
  bit          movl  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          msatm [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int          mmax  [4] = '{31, 31, 3, 3};
  int          step_no = 0;

  task automatic model_reset();
    mpat = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      mhist[k] = '0; mn[k] = 0; mc[k] = 0; ms[k] = 1'b0;
    end
  endtask

  task automatic drive(input bit v, input bit d, input bit ld, input logic [3:0] pv, input bit clr);
    exp_t e;
    bit   m;
    e = '0;
    din_valid = v; din = d; pat_load = ld; pat_value = pv; cnt_clr = clr;
    for (int k = 0; k < 4; k++) begin
      if (ld) begin
        mhist[k] = '0; mn[k] = 0; mc[k] = 0; ms[k] = 1'b0;
        m = 1'b0;
      end else begin
        m = v && (mn[k] >= 3) && ({mhist[k][2:0], d} == mpat);
        if (v) begin
          if (m && !movl[k]) begin
            mhist[k] = '0; mn[k] = 0;
          end else begin
            mhist[k] = {mhist[k][30:0], d}; mn[k]++;
          end
        end
        if (clr) begin
          mc[k] = m ? 1 : 0; ms[k] = 1'b0;
        end else if (m) begin
          if (msatm[k]) begin
            if (mc[k] == mmax[k]) ms[k] = 1'b1;
            else mc[k]++;
          end else begin
            mc[k] = (mc[k] + 1) % (mmax[k] + 1);
            if (mc[k] == 0) ms[k] = 1'b1;
          end
        end
      end
      e.h[k] = m;
      e.s[k] = ms[k];
      e.c[k] = 5'(mc[k]);
    end
    if (ld) mpat = pv;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i], 1'b0, 4'b0000, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    logic [3:0]      ah, as_;
    logic [3:0][4:0] ac;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      step_no++;
      ah = {h3, h2, h1, h0};
      as_ = {s3, s2, s1, s0};
      ac = {{3'b000, c3}, {3'b000, c2}, c1, c0};
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ah[k] !== e.h[k]) begin
          failures++;
          $display("FAIL sb_hit dut%0d step=%0d got=%b exp=%b", k, step_no, ah[k], e.h[k]);
        end
        checks++;
        if (ac[k] !== e.c[k]) begin
          failures++;
          $display("FAIL sb_count dut%0d step=%0d got=%0d exp=%0d", k, step_no, ac[k], e.c[k]);
        end
        checks++;
        if (as_[k] !== e.s[k]) begin
          failures++;
          $display("FAIL sb_sat dut%0d step=%0d got=%b exp=%b", k, step_no, as_[k], e.s[k]);
        end
      end
    end
  end

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({h0, h1, h2, h3, s0, s1, s2, s3} !== 8'h00 || c0 !== 5'd0 || c1 !== 5'd0 || c2 !== 2'd0 || c3 !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=h%b%b%b%b s%b%b%b%b c%0d/%0d/%0d/%0d exp=all zero",
               h0, h1, h2, h3, s0, s1, s2, s3, c0, c1, c2, c3);
    end
    #8 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [9:0] hv;
    logic [9:0] seq;
    hv = '0;
    seq = 10'b1011001011;
    drive(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, seq[9-i], 1'b0, 4'b0000, 1'b0);
      hv[i] = h0;
    end
    checks++;
    if (hv !== 10'b1000001000) begin
      failures++; $display("FAIL basic_hit_pos got=%b exp=%b", hv, 10'b1000001000);
    end
    checks++;
    if (c0 !== 5'd2 || s0 !== 1'b0) begin
      failures++; $display("FAIL basic_count got=%0d sat=%b exp=2 sat=0", c0, s0);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] hv0, hv1;
    logic [6:0] seq;
    seq = 7'b1011011;
    drive(1'b1, 1'b0, 1'b1, 4'b1011, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, seq[6-i], 1'b0, 4'b0000, 1'b0);
      hv0[i] = h0; hv1[i] = h1;
    end
    checks++;
    if (hv0 !== 7'b1001000 || c0 !== 5'd2) begin
      failures++; $display("FAIL overlap_on got=%b cnt=%0d exp=%b cnt=2", hv0, c0, 7'b1001000);
    end
    checks++;
    if (hv1 !== 7'b0001000 || c1 !== 5'd1) begin
      failures++; $display("FAIL overlap_off got=%b cnt=%0d exp=%b cnt=1", hv1, c1, 7'b0001000);
    end
  endtask

  task automatic test_gaps();
    logic [6:0] hv;
    drive(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0); hv[0] = h0;
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0); hv[1] = h0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0], 1'b0, 4'b0000, 1'b0); hv[2+i] = h0;
    end
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0); hv[5] = h0;
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0); hv[6] = h0;
    checks++;
    if (hv !== 7'b1000000 || c0 !== 5'd1) begin
      failures++; $display("FAIL gaps got=%b cnt=%0d exp=%b cnt=1", hv, c0, 7'b1000000);
    end
  endtask

  task automatic test_counter_limits();
    drive(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    for (int r = 0; r < 5; r++) begin
      send_bits(32'b1011, 4);
      if (r == 3) begin
        checks++;
        if (c2 !== 2'd3 || s2 !== 1'b1) begin
          failures++; $display("FAIL sat_4th got=%0d sat=%b exp=3 sat=1", c2, s2);
        end
        checks++;
        if (c3 !== 2'd0 || s3 !== 1'b1) begin
          failures++; $display("FAIL wrap_4th got=%0d sat=%b exp=0 sat=1", c3, s3);
        end
      end
    end
    checks++;
    if (c2 !== 2'd3 || s2 !== 1'b1 || c3 !== 2'd1 || s3 !== 1'b1 || c0 !== 5'd5) begin
      failures++;
      $display("FAIL limits_5th got=%0d/%b %0d/%b c0=%0d exp=3/1 1/1 c0=5", c2, s2, c3, s3, c0);
    end
  endtask

  task automatic test_load_and_clear();
    drive(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    send_bits(32'b101, 3);
    drive(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    checks++;
    if (c0 !== 5'd0 || h0 !== 1'b0) begin
      failures++; $display("FAIL load_clears got=%0d hit=%b exp=0 hit=0", c0, h0);
    end
    send_bits(32'b0110, 4);
    checks++;
    if (h0 !== 1'b1 || c0 !== 5'd1) begin
      failures++; $display("FAIL new_pattern got hit=%b cnt=%0d exp hit=1 cnt=1", h0, c0);
    end
    send_bits(32'b11, 2);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    checks++;
    if (h0 !== 1'b1 || c0 !== 5'd1 || s0 !== 1'b0 || c1 !== 5'd0) begin
      failures++;
      $display("FAIL clr_on_hit got hit=%b cnt=%0d sat=%b c1=%0d exp 1 1 0 0", h0, c0, s0, c1);
    end
  endtask

  task automatic test_back_to_back_reset();
    drive(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    send_bits(32'b101, 3);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (c0 !== 5'd0 || h0 !== 1'b0 || s0 !== 1'b0) begin
      failures++; $display("FAIL async_rst got cnt=%0d hit=%b sat=%b exp 0", c0, h0, s0);
    end
    #2 rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    checks++;
    if (h0 !== 1'b0 || c0 !== 5'd0) begin
      failures++; $display("FAIL rst_discard got hit=%b cnt=%0d exp hit=0 cnt=0", h0, c0);
    end
    send_bits(32'b1011, 4);
    checks++;
    if (h0 !== 1'b1 || c0 !== 5'd1) begin
      failures++; $display("FAIL after_rst got hit=%b cnt=%0d exp hit=1 cnt=1", h0, c0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_gaps();
    test_counter_limits();
    test_load_and_clear();
    test_back_to_back_reset();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
